// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller: arbitrates instruction fetch and load/store
// requests onto a byte-wide RAM/IO bus and returns assembled, extended results.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        wrong_commit,
    input  logic        inst_fetch_enable,
    input  logic [31:0] inst_fetch_addr,
    output logic        inst_valid,
    output logic [31:0] inst_res,
    input  logic        load_store_enable,
    input  logic [31:0] load_store_addr,
    input  logic [31:0] load_store_data,
    input  logic        load_or_store,
    input  logic [6:0]  load_store_op,
    output logic        mem_valid,
    output logic [31:0] mem_res
);
    localparam logic [6:0] LB  = 7'd0;
    localparam logic [6:0] LH  = 7'd1;
    localparam logic [6:0] LW  = 7'd2;
    localparam logic [6:0] LBU = 7'd3;
    localparam logic [6:0] LHU = 7'd4;
    localparam logic [6:0] SB  = 7'd5;
    localparam logic [6:0] SH  = 7'd6;
    localparam logic [6:0] SW  = 7'd7;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [6:0]  op_q, op_d;
    logic [31:0] buf_q, buf_d;
    logic [7:0]  skid_q, skid_d;
    logic        skid_vld_q, skid_vld_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_res_q, mem_res_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_res_q, inst_res_d;

    logic        io_stall_c;
    logic [7:0]  rd_byte_c;
    logic [1:0]  rd_idx_c;
    logic [31:0] word_c;
    logic [31:0] ext_c;

    function automatic logic [2:0] len_of(input logic [6:0] op);
        case (op)
            LB, LBU, SB: return 3'd1;
            LH, LHU, SH: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

    assign io_stall_c = !load_or_store && (load_store_addr[17:16] == 2'b11) && io_buffer_full;
    // The RAM keeps running while rdy is low, so the byte in flight at the first
    // stalled edge is parked and consumed on resume in place of the bus value.
    assign rd_byte_c  = skid_vld_q ? skid_q : mem_din;
    assign rd_idx_c   = 2'(cnt_q - 3'd2);

    always_comb begin
        word_c = buf_q;
        word_c[{rd_idx_c, 3'b000} +: 8] = rd_byte_c;
    end

    always_comb begin
        case (op_q)
            LB:      ext_c = {{24{word_c[7]}}, word_c[7:0]};
            LH:      ext_c = {{16{word_c[15]}}, word_c[15:0]};
            LBU:     ext_c = {24'd0, word_c[7:0]};
            LHU:     ext_c = {16'd0, word_c[15:0]};
            default: ext_c = word_c;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        op_d         = op_q;
        buf_d        = buf_q;
        skid_d       = skid_q;
        skid_vld_d   = skid_vld_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = mem_wr_q;
        mem_valid_d  = mem_valid_q;
        mem_res_d    = mem_res_q;
        inst_valid_d = inst_valid_q;
        inst_res_d   = inst_res_q;
        if (!rdy) begin
            if (!skid_vld_q) begin
                skid_d     = mem_din;
                skid_vld_d = 1'b1;
            end
        end else begin
            skid_vld_d   = 1'b0;
            mem_valid_d  = 1'b0;
            inst_valid_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_store_enable && !io_stall_c) begin
                        base_d  = load_store_addr;
                        wdata_d = load_store_data;
                        op_d    = load_store_op;
                        len_d   = len_of(load_store_op);
                        cnt_d   = 3'd1;
                        mem_a_d = load_store_addr;
                        if (load_or_store) begin
                            state_d  = S_LOAD;
                            mem_wr_d = 1'b0;
                        end else begin
                            state_d    = S_STORE;
                            mem_wr_d   = 1'b1;
                            mem_dout_d = load_store_data[7:0];
                        end
                    end else if (inst_fetch_enable && !wrong_commit) begin
                        base_d   = inst_fetch_addr;
                        len_d    = 3'd4;
                        cnt_d    = 3'd1;
                        mem_a_d  = inst_fetch_addr;
                        mem_wr_d = 1'b0;
                        state_d  = S_FETCH;
                    end
                end
                S_FETCH, S_LOAD: begin
                    if (state_q == S_FETCH && wrong_commit) begin
                        state_d = S_IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        if (cnt_q >= 3'd2) buf_d = word_c;
                        if (cnt_q < len_q) mem_a_d = base_q + 32'(cnt_q);
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'(len_q + 3'd1)) begin
                            state_d = S_DONE;
                            cnt_d   = 3'd0;
                            if (state_q == S_FETCH) begin
                                inst_valid_d = 1'b1;
                                inst_res_d   = word_c;
                            end else begin
                                mem_valid_d = 1'b1;
                                mem_res_d   = ext_c;
                            end
                        end
                    end
                end
                S_STORE: begin
                    if (cnt_q < len_q) begin
                        mem_a_d    = base_q + 32'(cnt_q);
                        mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                        cnt_d      = cnt_q + 3'd1;
                    end else begin
                        mem_wr_d    = 1'b0;
                        mem_valid_d = 1'b1;
                        mem_res_d   = 32'd0;
                        state_d     = S_DONE;
                        cnt_d       = 3'd0;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            len_q        <= 3'd0;
            base_q       <= 32'd0;
            wdata_q      <= 32'd0;
            op_q         <= 7'd0;
            buf_q        <= 32'd0;
            skid_q       <= 8'd0;
            skid_vld_q   <= 1'b0;
            mem_a_q      <= 32'd0;
            mem_dout_q   <= 8'd0;
            mem_wr_q     <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_res_q    <= 32'd0;
            inst_valid_q <= 1'b0;
            inst_res_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            op_q         <= op_d;
            buf_q        <= buf_d;
            skid_q       <= skid_d;
            skid_vld_q   <= skid_vld_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            mem_valid_q  <= mem_valid_d;
            mem_res_q    <= mem_res_d;
            inst_valid_q <= inst_valid_d;
            inst_res_q   <= inst_res_d;
        end
    end

    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    assign mem_wr     = mem_wr_q;
    assign mem_valid  = mem_valid_q;
    assign mem_res    = mem_res_q;
    assign inst_valid = inst_valid_q;
    assign inst_res   = inst_res_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM with 1-cycle read latency, shadow-memory reference
// model, directed cases and a randomized request loop.
`timescale 1ns/1ps
module tb_mem_ctrl;
    localparam logic [6:0] LB  = 7'd0;
    localparam logic [6:0] LH  = 7'd1;
    localparam logic [6:0] LW  = 7'd2;
    localparam logic [6:0] LBU = 7'd3;
    localparam logic [6:0] LHU = 7'd4;
    localparam logic [6:0] SB  = 7'd5;
    localparam logic [6:0] SH  = 7'd6;
    localparam logic [6:0] SW  = 7'd7;

    logic        clk, rst, rdy;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full, wrong_commit;
    logic        inst_fetch_enable, inst_valid;
    logic [31:0] inst_fetch_addr, inst_res;
    logic        load_store_enable, load_or_store, mem_valid;
    logic [31:0] load_store_addr, load_store_data, mem_res;
    logic [6:0]  load_store_op;

    int total = 0;
    int bad   = 0;
    logic [7:0]  seed;
    logic [7:0]  ram   [0:65535];
    logic        ram_w [0:65535];
    logic [7:0]  sh    [0:65535];
    logic        sh_w  [0:65535];
    logic [39:0] wlog  [$];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .wrong_commit(wrong_commit),
        .inst_fetch_enable(inst_fetch_enable), .inst_fetch_addr(inst_fetch_addr),
        .inst_valid(inst_valid), .inst_res(inst_res),
        .load_store_enable(load_store_enable), .load_store_addr(load_store_addr),
        .load_store_data(load_store_data), .load_or_store(load_or_store),
        .load_store_op(load_store_op), .mem_valid(mem_valid), .mem_res(mem_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return 8'(a[7:0] * 8'd167) ^ a[15:8] ^ seed;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram_w[a[15:0]] ? ram[a[15:0]] : init_byte(a[15:0]);
    endfunction

    function automatic logic [7:0] sh_rd(input logic [31:0] a);
        return sh_w[a[15:0]] ? sh[a[15:0]] : init_byte(a[15:0]);
    endfunction

    // RAM: writes land at the edge, read data appears one cycle after the address.
    always @(posedge clk) begin
        if (mem_wr) begin
            ram[mem_a[15:0]]   <= mem_dout;
            ram_w[mem_a[15:0]] <= 1'b1;
            if (rdy) wlog.push_back({mem_a, mem_dout});
        end
        mem_din <= ram_rd(mem_a);
    end

    function automatic int n_of(input logic [6:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic bit is_ld(input logic [6:0] op);
        return op == LB || op == LH || op == LW || op == LBU || op == LHU;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [6:0] op, input bit fetch);
        int n = fetch ? 4 : n_of(op);
        logic [31:0] w = 32'd0;
        for (int i = 0; i < n; i++) w = w + (32'(sh_rd(a + 32'(i))) << (8 * i));
        if (fetch) return w;
        if (op == LB && w[7])  return w | 32'hFFFF_FF00;
        if (op == LH && w[15]) return w | 32'hFFFF_0000;
        return w;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] ai = a + 32'(i);
            sh[ai[15:0]]   = d[8 * i +: 8];
            sh_w[ai[15:0]] = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic finish_req();
        @(posedge clk); #1;
        chk("pulse_once", {inst_valid, mem_valid}, 0);
        inst_fetch_enable = 1'b0;
        load_store_enable = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("no_dup", {mem_wr, inst_valid, mem_valid}, 0);
    endtask

    task automatic do_req(input bit fetch, input logic [31:0] a, input logic [31:0] d,
                          input logic [6:0] op, input int stall_at, input int stall_len,
                          output logic [31:0] res);
        bit          ld      = fetch || is_ld(op);
        int          n       = fetch ? 4 : n_of(op);
        int          exp_lat = (ld ? n + 2 : n + 1) + stall_len;
        logic [31:0] exp     = ld ? model_read(a, op, fetch) : 32'd0;
        int          w0      = wlog.size();
        int          cyc     = 0;
        bit          seen    = 1'b0;
        if (fetch) begin
            inst_fetch_addr   = a;
            inst_fetch_enable = 1'b1;
        end else begin
            load_store_addr   = a;
            load_store_data   = d;
            load_store_op     = op;
            load_or_store     = ld;
            load_store_enable = 1'b1;
        end
        while (!seen && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (stall_len > 0 && cyc == stall_at) rdy = 1'b0;
            if (stall_len > 0 && cyc == stall_at + stall_len) rdy = 1'b1;
            seen = fetch ? inst_valid : mem_valid;
        end
        rdy = 1'b1;
        res = fetch ? inst_res : mem_res;
        chk("done", seen, 1);
        chk("latency", cyc, exp_lat);
        chk(ld ? "load_res" : "store_res", res, exp);
        if (ld) begin
            chk("read_no_wr", wlog.size() - w0, 0);
        end else begin
            chk("wr_count", wlog.size() - w0, n);
            for (int i = 0; i < n && w0 + i < wlog.size(); i++)
                chk("wr_byte", wlog[w0 + i], {a + 32'(i), d[8 * i +: 8]});
            model_store(a, d, n);
        end
        finish_req();
    endtask

    task automatic arb_test();
        int          w0 = wlog.size();
        int          cyc = 0, cyc_m = 0;
        bit          got_m = 1'b0, got_i = 1'b0, order_ok = 1'b1, drop = 1'b0;
        logic [31:0] ires = 32'd0;
        load_store_addr = 32'h50; load_store_data = 32'hA7; load_store_op = SB;
        load_or_store = 1'b0; load_store_enable = 1'b1;
        inst_fetch_addr = 32'h50; inst_fetch_enable = 1'b1;
        while (!got_i && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (drop) begin load_store_enable = 1'b0; drop = 1'b0; end
            if (mem_valid && !got_m) begin got_m = 1'b1; drop = 1'b1; cyc_m = cyc; end
            if (inst_valid) begin got_i = 1'b1; ires = inst_res; if (!got_m) order_ok = 1'b0; end
        end
        model_store(32'h50, 32'hA7, 1);
        chk("arb_order", {got_i, order_ok}, 2'b11);
        chk("arb_sb_lat", cyc_m, 2);
        chk("arb_fetch", ires, model_read(32'h50, LW, 1'b1));
        chk("arb_wr_n", wlog.size() - w0, 1);
        if (wlog.size() > w0) chk("arb_wr", wlog[w0], {32'h50, 8'hA7});
        finish_req();
    endtask

    task automatic io_test();
        int w0 = wlog.size();
        int cyc = 0;
        bit seen = 1'b0;
        io_buffer_full = 1'b1;
        load_store_addr = 32'h0003_0004; load_store_data = 32'h5A; load_store_op = SB;
        load_or_store = 1'b0; load_store_enable = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("io_hold_wr", wlog.size() - w0, 0);
        chk("io_hold_valid", mem_valid, 0);
        io_buffer_full = 1'b0;
        while (!seen && cyc < 20) begin @(posedge clk); #1; cyc++; seen = mem_valid; end
        chk("io_lat", cyc, 2);
        chk("io_wr_n", wlog.size() - w0, 1);
        if (wlog.size() > w0) chk("io_wr", wlog[w0], {32'h0003_0004, 8'h5A});
        model_store(32'h0003_0004, 32'h5A, 1);
        finish_req();
    endtask

    task automatic flush_fetch_test();
        int got = 0;
        inst_fetch_addr = 32'h200; inst_fetch_enable = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        wrong_commit = 1'b1; inst_fetch_enable = 1'b0;
        @(posedge clk); #1;
        wrong_commit = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (inst_valid) got++; end
        chk("flush_no_valid", got, 0);
    endtask

    function automatic logic [6:0] pick_op(input int i);
        case (i)
            0: return LB;  1: return LH;  2: return LW;  3: return LBU;
            4: return LHU; 5: return SB;  6: return SH;  default: return SW;
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        seed = 8'($urandom);
        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; wrong_commit = 1'b0;
        inst_fetch_enable = 1'b0; inst_fetch_addr = 32'd0;
        load_store_enable = 1'b0; load_store_addr = 32'd0; load_store_data = 32'd0;
        load_or_store = 1'b0; load_store_op = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_a", mem_a, 0);
        chk("rst_dout_wr", {mem_dout, mem_wr}, 0);
        chk("rst_mem_out", {mem_valid, mem_res}, 0);
        chk("rst_inst_out", {inst_valid, inst_res}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_req(1'b0, 32'h1000, 32'h0000_0513, SW, 0, 0, r);
        do_req(1'b1, 32'h1000, 32'd0, LW, 0, 0, r);
        chk("fetch_513", r, 32'h0000_0513);
        do_req(1'b0, 32'h20, 32'h80, SB, 0, 0, r);
        do_req(1'b0, 32'h20, 32'd0, LB, 0, 0, r);
        chk("lb_80", r, 32'hFFFF_FF80);
        do_req(1'b0, 32'h20, 32'd0, LBU, 0, 0, r);
        chk("lbu_80", r, 32'h0000_0080);
        do_req(1'b0, 32'h40, 32'hFFFF, SH, 0, 0, r);
        do_req(1'b0, 32'h40, 32'd0, LH, 0, 0, r);
        chk("lh_ffff", r, 32'hFFFF_FFFF);
        do_req(1'b0, 32'h40, 32'd0, LHU, 0, 0, r);
        chk("lhu_ffff", r, 32'h0000_FFFF);
        do_req(1'b0, 32'h100, 32'hDEAD_BEEF, SW, 0, 0, r);
        do_req(1'b0, 32'h100, 32'd0, LW, 0, 0, r);
        chk("lw_deadbeef", r, 32'hDEAD_BEEF);

        arb_test();
        io_test();
        flush_fetch_test();

        wrong_commit = 1'b1;
        do_req(1'b0, 32'h60, 32'h1234, SH, 0, 0, r);
        wrong_commit = 1'b0;
        do_req(1'b0, 32'h60, 32'd0, LHU, 0, 0, r);
        chk("sh_under_flush", r, 32'h0000_1234);

        do_req(1'b0, 32'h100, 32'd0, LW, 2, 3, r);
        chk("lw_stalled", r, 32'hDEAD_BEEF);
        do_req(1'b0, 32'hFFFF_FFFF, 32'hA1B2, SH, 0, 0, r);
        do_req(1'b0, 32'hFFFF_FFFF, 32'd0, LH, 0, 0, r);
        chk("lh_wrap", r, 32'hFFFF_A1B2);

        for (int t = 0; t < 200; t++) begin
            int          sel   = int'($urandom_range(0, 7));
            bit          fetch = ($urandom_range(0, 3) == 0);
            logic [6:0]  op    = pick_op(int'($urandom_range(0, 7)));
            logic [31:0] a, d;
            int          n, sa, sl;
            d = $urandom;
            if (sel < 6)       a = 32'h100 + 32'($urandom_range(0, 255));
            else if (sel == 6) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else               a = 32'h0003_0000 + 32'($urandom_range(0, 15));
            n  = fetch ? 4 : n_of(op);
            sl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            sa = int'($urandom_range(1, n));
            do_req(fetch, a, d, op, sa, sl, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
